d_flip_flop: RTL and testbench
==============================

Name: d_flip_flop

Overview:
- Parameterised D-type register with complementary outputs, an asynchronous active-high reset and a synchronous active-low clear.
- Used as the basic storage element in datapath and control logic wherever a registered value and its inverse are both needed.
- Default WIDTH=1 gives a single-bit flip-flop.

Parameters:
- WIDTH, 1, number of data bits stored.
- RESET_VALUE, 0 (WIDTH bits), value loaded into q on reset and on clear.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high.
- clear_n  input  1  synchronous clear, active-low.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data.
- q_bar  output  WIDTH  bitwise inverse of q.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset:
  - reset=1 immediately forces q=RESET_VALUE and q_bar=~RESET_VALUE, independent of clk.
  - The forced value holds for as long as reset is asserted.
  - Deassertion takes effect at the next rising clk edge.
- Priority at each rising clk edge (reset deasserted):
  - clear_n=0: q <= RESET_VALUE.
  - Otherwise: q <= d.
- Latency: d is visible on q one clock after the sampling edge; no combinational path from d to q.
- q_bar is always exactly ~q. It is derived combinationally from the same register, so there is no cycle where q_bar==q.
- Simultaneous reset=1 and clear_n=0: reset wins; the result is identical (RESET_VALUE).
- Reset asserted mid-cycle: q changes immediately. It does not wait for the next edge.
- clear_n deasserting and d changing on the same edge: the clear still applies on that edge; d is captured from the following edge.
- X/Z on d is not filtered; it propagates to q as in standard RTL semantics.
- Implementation scope: register bank, output inversion, optional edge detector, parameter checks (WIDTH>=1 enforced by an elaboration-time error).

Optional Feature:
- Macro: D_FLIP_FLOP_EDGE_DET_EN.
- When defined, the block adds two outputs:
  - q_rise: WIDTH bits; a bit is 1 for one cycle when that q bit went 0->1 on the last edge.
  - q_fall: WIDTH bits; a bit is 1 for one cycle when that q bit went 1->0 on the last edge.
- Both outputs are registered and derived from the q history register. They are 0 during reset and in the first cycle after reset release.
- A clear that changes q does generate fall pulses.
- When undefined, these ports and the history register do not exist; the remaining behaviour is unchanged.

Decomposition:
- Shared package d_flip_flop_pkg holds:
  - default WIDTH constant;
  - RESET_VALUE default;
  - a localparam for the all-ones mask used in the q_bar check.
- No sub-module needed for the base register.
- The optional edge detector is a natural sub-module: d_flip_flop_edge_det (inputs clk, reset, q; outputs q_rise, q_fall).

Test Plan:
- reset=1, clear_n=1, d=1 for 10 edges -> q=0, q_bar=1 throughout; assert reset between edges -> q drops to 0 without waiting for an edge.
- reset=0, clear_n=0, d=1 for 10 edges -> q stays 0, q_bar stays 1.
- clear_n=1, d=1 -> q=1 after the next edge; d=0 -> q=0 after the next edge; q_bar always the inverse.
- 50 random d values with clear_n=1 -> q equals d from the previous edge every cycle; q_bar==~q every cycle.
- q=1, then reset=1 and clear_n=0 together -> q=0; release reset with clear_n=0 -> q stays 0; release clear_n with d=1 -> q=1 one edge later.
- With D_FLIP_FLOP_EDGE_DET_EN and WIDTH=4:
  - d sequence 0000 -> 0101 -> 0001 gives q_rise=0101 for one cycle;
  - then q_fall=0100 for one cycle;
  - otherwise q_rise and q_fall are 0000.

Source files
------------

// File: rtl/d_flip_flop_pkg.sv
// d_flip_flop_pkg
// Shared constants for the d_flip_flop register and its optional edge detector.
//   DefaultWidth      - default number of stored bits
//   MaxWidth          - widest register the shared constants cover
//   DefaultResetValue - default value loaded on reset and on clear
//   AllOnesMask       - all-ones pattern used to check that q_bar is exactly ~q
package d_flip_flop_pkg;

  localparam int unsigned DefaultWidth = 1;
  localparam int unsigned MaxWidth     = 64;

  localparam logic [MaxWidth-1:0] DefaultResetValue = '0;
  localparam logic [MaxWidth-1:0] AllOnesMask       = '1;

endpackage

// File: rtl/d_flip_flop_edge_det.sv
// d_flip_flop_edge_det
// Registered per-bit rise/fall detector driven by the q output of d_flip_flop.
// The history register holds q from the previous edge. Each pulse register
// captures a transition seen between the last two q values.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous reset, active-high (history <- RESET_VALUE, pulses <- 0)
//   q      - register value being watched
//   q_rise - per-bit 0->1 pulse, one cycle wide
//   q_fall - per-bit 1->0 pulse, one cycle wide
module d_flip_flop_edge_det
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned      WIDTH       = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VALUE = DefaultResetValue[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;

  always_comb begin
    rise_d = q & ~hist_q;
    fall_d = ~q & hist_q;
  end

  // History resets to RESET_VALUE, matching q, so no pulse appears right
  // after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      hist_q <= q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_rise = rise_q;
  assign q_fall = fall_q;

endmodule

// File: rtl/d_flip_flop.sv
// d_flip_flop
// Parameterised D register with complementary outputs, asynchronous active-high
// reset and synchronous active-low clear. Reset has priority over clear. Both
// load RESET_VALUE.
// Optional feature: define D_FLIP_FLOP_EDGE_DET_EN to add the q_rise/q_fall
// edge-detector outputs.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous reset, active-high
//   clear_n - synchronous clear, active-low
//   d       - data input (WIDTH bits)
//   q_rise  - (D_FLIP_FLOP_EDGE_DET_EN only) per-bit 0->1 pulse
//   q_fall  - (D_FLIP_FLOP_EDGE_DET_EN only) per-bit 1->0 pulse
//   q       - registered data
//   q_bar   - bitwise inverse of q
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned      WIDTH       = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VALUE = DefaultResetValue[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] d,
`ifdef D_FLIP_FLOP_EDGE_DET_EN
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  if (WIDTH < 1 || WIDTH > MaxWidth) begin : gen_width_check
    $error("d_flip_flop: WIDTH must be in 1..%0d", MaxWidth);
  end

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = d;
    if (!clear_n) begin
      q_d = RESET_VALUE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Both outputs come from the same flop, so they can never be equal.
  assign q     = q_q;
  assign q_bar = ~q_q;

  assert property (@(posedge clk) disable iff (reset)
                   (q ^ q_bar) == AllOnesMask[WIDTH-1:0]);

`ifdef D_FLIP_FLOP_EDGE_DET_EN
  d_flip_flop_edge_det #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_edge_det (
    .clk    (clk),
    .reset  (reset),
    .q      (q_q),
    .q_rise (q_rise),
    .q_fall (q_fall)
  );
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop
// Scoreboard bench for d_flip_flop (WIDTH=4, RESET_VALUE=0). Inputs change on
// the falling edge, and the reference model pushes the state expected after
// the next rising edge. A monitor pops one entry 1 ns after each rising edge
// and compares it with the DUT outputs.
module tb_d_flip_flop;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] Rv = '0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk_tb = 1'b0;
  logic         reset = 1'b1;
  logic         clear_n = 1'b1;
  logic [W-1:0] d = '0;
  logic [W-1:0] q, q_bar;
`ifdef D_FLIP_FLOP_EDGE_DET_EN
  logic [W-1:0] q_rise, q_fall;
`endif

  int total = 0;
  int bad = 0;

  exp_t         exp_q[$];
  logic [W-1:0] q_hist[$];  // q value after each modelled edge

  always #5 clk_tb = ~clk_tb;

  d_flip_flop #(
    .WIDTH       (W),
    .RESET_VALUE (Rv)
  ) dut (
    .clk     (clk_tb),
    .reset   (reset),
    .clear_n (clear_n),
    .d       (d),
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    .q_rise  (q_rise),
    .q_fall  (q_fall),
`endif
    .q       (q),
    .q_bar   (q_bar)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: what one rising edge should produce for these inputs.
  task automatic model_edge(input logic r, input logic c, input logic [W-1:0] dv);
    exp_t e;
    logic [W-1:0] nq;
    if (r) begin
      // Reset forces q and the detector's notion of the previous q to Rv.
      q_hist = '{Rv, Rv};
      e = '{q: Rv, rise: '0, fall: '0};
    end else begin
      nq = c ? dv : Rv;
      // Pulses report the transition between the two most recent q values.
      e.q    = nq;
      e.rise = q_hist[$] & ~q_hist[$-1];
      e.fall = ~q_hist[$] & q_hist[$-1];
      q_hist.push_back(nq);
      if (q_hist.size() > 4) void'(q_hist.pop_front());
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic c, input logic [W-1:0] dv);
    @(negedge clk_tb);
    reset   = r;
    clear_n = c;
    d       = dv;
    model_edge(r, c, dv);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_tb);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", q, e.q);
        chk("q_bar", q_bar, ~e.q);
`ifdef D_FLIP_FLOP_EDGE_DET_EN
        chk("q_rise", q_rise, e.rise);
        chk("q_fall", q_fall, e.fall);
`endif
      end
    end
  end

  initial begin
    logic [W-1:0] ones;
    ones = '1;

    // Reset held with d all ones: q must stay at the reset value.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, ones);
    // Clear held: q stays at the reset value.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, ones);
    // Basic capture.
    step(1'b0, 1'b1, ones);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, ones);
    step(1'b0, 1'b1, ones);

    // Asynchronous reset between edges.
    @(posedge clk_tb);
    #3;
    reset = 1'b1;
    #1;
    chk("async_q", q, Rv);
    chk("async_q_bar", q_bar, ~Rv);
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    chk("async_rise", q_rise, '0);
    chk("async_fall", q_fall, '0);
`endif
    step(1'b1, 1'b1, ones);
    step(1'b1, 1'b1, ones);

    // Random data with clear inactive.
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, W'($urandom));

    // Reset and clear together, then release reset, then release clear.
    step(1'b0, 1'b1, ones);
    step(1'b1, 1'b0, ones);
    step(1'b0, 1'b0, ones);
    step(1'b0, 1'b1, ones);
    step(1'b0, 1'b1, ones);

    // Edge-detector sequence 0000 -> 0101 -> 0001, then hold.
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0101);
    step(1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0001);

    // Random data with occasional clear.
    for (int i = 0; i < 40; i++) step(1'b0, ($urandom_range(0, 4) != 0), W'($urandom));

    // Drain the scoreboard.
    repeat (3) @(negedge clk_tb);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
